// File: rtl/rp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rp_cmd_sequencer
// Description : Byte-stream command sequencer for a compiled ripstop DUT.
//               Decodes single-byte host commands ('h' read, 'i' quit,
//               'j'/'k' DUT reset control, 'l' step, 'm' load inputs), owns
//               the DUT reset, step enable and input vector, and serializes
//               the DUT output vector back to the host LSB first.
// Revision    : 1.0  initial release
// ============================================================================
module rp_cmd_sequencer #(
  parameter int INPUT_BYTES  = 4,
  parameter int OUTPUT_WORDS = 1,
  parameter int STEP_CYCLES  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                cmd_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [7:0]                rsp_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  input  logic [OUTPUT_WORDS*32-1:0] dut_out,
  output logic [INPUT_BYTES*8-1:0]  dut_in,
  output logic                      dut_rst,
  output logic                      dut_step,
  output logic                      done,
  output logic                      error,
  output logic [7:0]                err_code
);

  localparam int IN_W      = INPUT_BYTES * 8;
  localparam int OUT_W     = OUTPUT_WORDS * 32;
  localparam int OUT_BYTES = OUTPUT_WORDS * 4;
  localparam int LCW       = $clog2(INPUT_BYTES + 1);
  localparam int SCW       = $clog2(STEP_CYCLES + 1);
  localparam int BCW       = $clog2(OUT_BYTES + 1);

  localparam logic [LCW-1:0] C_LOAD_LAST = LCW'(INPUT_BYTES - 1);
  localparam logic [SCW-1:0] C_STEP_LAST = SCW'(STEP_CYCLES);
  localparam logic [BCW-1:0] C_SEND_LAST = BCW'(OUT_BYTES - 1);

  localparam logic [7:0] C_CMD_READ  = 8'h68;
  localparam logic [7:0] C_CMD_QUIT  = 8'h69;
  localparam logic [7:0] C_CMD_RSTON = 8'h6A;
  localparam logic [7:0] C_CMD_RSTOF = 8'h6B;
  localparam logic [7:0] C_CMD_STEP  = 8'h6C;
  localparam logic [7:0] C_CMD_LOAD  = 8'h6D;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_SEND = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  state_t            state_q,     state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q,  rsp_data_d;
  logic [IN_W-1:0]   dut_in_q,    dut_in_d;
  logic [IN_W-1:0]   shadow_q,    shadow_d;
  logic              dut_rst_q,   dut_rst_d;
  logic              dut_step_q,  dut_step_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;
  logic [7:0]        err_code_q,  err_code_d;
  logic [OUT_W-1:0]  snap_q,      snap_d;
  logic [LCW-1:0]    load_cnt_q,  load_cnt_d;
  logic [SCW-1:0]    step_cnt_q,  step_cnt_d;
  logic [BCW-1:0]    byte_idx_q,  byte_idx_d;

  logic              w_accept;
  logic              w_rsp_xfer;
  logic [IN_W+7:0]   w_shift;

  assign w_accept   = cmd_valid && cmd_ready_q;
  assign w_rsp_xfer = rsp_valid_q && rsp_ready;
  // New byte enters at the top so the first byte of a load ends up lowest.
  assign w_shift    = {cmd_data, shadow_q};

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    dut_in_d    = dut_in_q;
    shadow_d    = shadow_q;
    dut_rst_d   = dut_rst_q;
    dut_step_d  = dut_step_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    snap_d      = snap_q;
    load_cnt_d  = load_cnt_q;
    step_cnt_d  = step_cnt_q;
    byte_idx_d  = byte_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_data)
            C_CMD_READ: begin
              // First byte goes out immediately; the rest stays in the snapshot.
              rsp_data_d  = dut_out[7:0];
              snap_d      = dut_out >> 8;
              byte_idx_d  = '0;
              rsp_valid_d = 1'b1;
              state_d     = ST_SEND;
            end
            C_CMD_QUIT: begin
              done_d  = 1'b1;
              state_d = ST_HALT;
            end
            C_CMD_RSTON: dut_rst_d = 1'b1;
            C_CMD_RSTOF: dut_rst_d = 1'b0;
            C_CMD_STEP: begin
              dut_step_d = 1'b1;
              step_cnt_d = SCW'(1);
              state_d    = ST_STEP;
            end
            C_CMD_LOAD: begin
              load_cnt_d = '0;
              state_d    = ST_LOAD;
            end
            default: begin
              error_d    = 1'b1;
              err_code_d = cmd_data;
              state_d    = ST_HALT;
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (w_accept) begin
          shadow_d = w_shift[IN_W+7:8];
          if (load_cnt_q == C_LOAD_LAST) begin
            // Whole vector transfers at once so the DUT never sees a partial load.
            dut_in_d   = w_shift[IN_W+7:8];
            load_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end

      ST_STEP: begin
        if (step_cnt_q == C_STEP_LAST) begin
          dut_step_d = 1'b0;
          step_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end

      ST_SEND: begin
        if (w_rsp_xfer) begin
          if (byte_idx_q == C_SEND_LAST) begin
            rsp_valid_d = 1'b0;
            byte_idx_d  = '0;
            state_d     = ST_IDLE;
          end else begin
            rsp_data_d = snap_q[7:0];
            snap_d     = snap_q >> 8;
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      ST_HALT: begin
        rsp_valid_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    // Ready is registered, so it follows the state being entered.
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      dut_in_q    <= '0;
      shadow_q    <= '0;
      dut_rst_q   <= 1'b1;
      dut_step_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      snap_q      <= '0;
      load_cnt_q  <= '0;
      step_cnt_q  <= '0;
      byte_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      dut_in_q    <= dut_in_d;
      shadow_q    <= shadow_d;
      dut_rst_q   <= dut_rst_d;
      dut_step_q  <= dut_step_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      snap_q      <= snap_d;
      load_cnt_q  <= load_cnt_d;
      step_cnt_q  <= step_cnt_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign dut_in    = dut_in_q;
  assign dut_rst   = dut_rst_q;
  assign dut_step  = dut_step_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: doc/rp_cmd_sequencer.md
Name: rp_cmd_sequencer

Overview:
Synthesizable command sequencer that drives a compiled ripstop DUT from a byte-stream command channel. It uses the same command alphabet as the simulation harness: 'h' read outputs, 'i' quit, 'j'/'k' reset control, 'l' step, 'm' load inputs. It sits between a host byte link (UART/FIFO) and the DUT. It owns the DUT's reset, clock-enable (step) and input vector, and serializes DUT outputs back to the host.

Parameters:
INPUT_BYTES, 4, number of bytes in the DUT input vector; legal values are 1 or more.
OUTPUT_WORDS, 1, number of 32-bit words in the DUT output vector; legal values are 1 or more.
STEP_CYCLES, 3, number of consecutive cycles dut_step is held high per 'l' command; legal values are 1 or more.

Ports:
clk  input  1  single clock for the whole block.
rst  input  1  synchronous, active-high reset.
cmd_data  input  8  command or payload byte from the host.
cmd_valid  input  1  cmd_data is valid.
cmd_ready  output  1  block accepts cmd_data; a transfer occurs when cmd_valid && cmd_ready at a clk edge.
rsp_data  output  8  response byte to the host.
rsp_valid  output  1  rsp_data is valid.
rsp_ready  input  1  host accepts rsp_data.
dut_out  input  OUTPUT_WORDS*32  DUT output vector.
dut_in  output  INPUT_BYTES*8  DUT input vector.
dut_rst  output  1  reset driven to the DUT.
dut_step  output  1  clock-enable pulse for the DUT.
done  output  1  sticky; set by the quit command.
error  output  1  sticky; set by an illegal command.
err_code  output  8  the offending command byte.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0;
  - dut_in=0, load shadow=0, dut_rst=1, dut_step=0;
  - done=0, error=0, err_code=0.
  - cmd_ready rises the first cycle after rst deasserts.
- Reset mid-operation: any state returns to the reset values. Partial loads, in-flight responses and remaining step cycles are discarded.
- States are IDLE, LOAD, STEP, SEND and HALT. All outputs are registered.
- IDLE: cmd_ready=1. On an accepted byte:
  - 0x68 'h': snapshot dut_out as sampled at the accept edge, set byte index to 0, go to SEND.
  - 0x69 'i': done=1, go to HALT.
  - 0x6A 'j': dut_rst=1 from the next cycle; stay in IDLE.
  - 0x6B 'k': dut_rst=0 from the next cycle; stay in IDLE.
  - 0x6C 'l': go to STEP; dut_step=1 from the next cycle.
  - 0x6D 'm': go to LOAD with byte count 0.
  - Any other value: error=1, err_code=byte, go to HALT.
- LOAD: cmd_ready=1.
  - Each accepted byte shifts into the shadow register: shadow = {byte, shadow[top:8]}. The first byte received ends up least significant.
  - After the INPUT_BYTES-th byte, dut_in is loaded from the completed shadow value in one update, effective the next cycle. The state returns to IDLE.
  - dut_in never shows a partial value.
- STEP: cmd_ready=0.
  - dut_step is high for exactly STEP_CYCLES consecutive cycles, then 0.
  - IDLE is re-entered in the cycle dut_step falls.
  - dut_rst is unchanged during STEP.
- SEND: cmd_ready=0, rsp_valid=1.
  - Byte order: word 0 first; within each word, least significant byte first (matches the harness "%u" format).
  - rsp_data advances only when rsp_valid && rsp_ready. While rsp_ready=0, rsp_data and rsp_valid hold stable.
  - After the final byte (OUTPUT_WORDS*4) is accepted, rsp_valid=0 next cycle and the state returns to IDLE.
  - dut_out changes after the snapshot have no effect on the bytes sent.
- HALT: cmd_ready=0 and rsp_valid=0 until rst. done and error hold their values. dut_in and dut_rst hold their values.
- Counters are sized with $clog2(max+1). The byte index wraps only via the state exit; no modular wrap occurs inside a command.
- Simultaneous cmd_valid and rst: rst wins and the byte is not consumed.

Test Plan:
- Reset then release: while rst is high, dut_rst=1, dut_in=0, cmd_ready=0. cmd_ready=1 on the first cycle after release.
- Send 0x6D,0x11,0x22,0x33,0x44 (INPUT_BYTES=4): dut_in stays 0 until 0x44 is accepted, then reads 0x44332211 the next cycle. The state returns to IDLE.
- Send 0x6C (STEP_CYCLES=3): dut_step is high for exactly 3 cycles with cmd_ready=0 throughout. cmd_ready=1 the cycle dut_step falls. A second 0x6C gives 3 more cycles.
- With dut_out=0xDEADBEEF, send 0x68 and toggle rsp_ready 1,0,0,1,1,1. Bytes are EF,BE,AD,DE in order, held stable during the stalls. Changing dut_out after the accept does not alter the bytes.
- Send 0x6B, then 0x6A: dut_rst goes 1→0 the cycle after 0x6B and 0→1 after 0x6A. Send 0x71: error=1, err_code=0x71, cmd_ready stays 0. In a separate run, 0x69 sets done=1 and cmd_ready=0.
- Send 0x6D,0xAA,0xBB, then pulse rst: dut_in=0. A subsequent full load of 0x01,0x02,0x03,0x04 gives dut_in=0x04030201 with no leftover 0xAA/0xBB bytes.
